// File: rtl/psr_flag_stack_if.sv
// Flag/stack control bundle between the ALU/sequencer side and the status register.
// The master drives the update, write and stack controls; the slave returns flags, occupancy and sticky errors.
interface psr_flag_stack_if #(
    parameter int G1_W  = 2,
    parameter int G2_W  = 3,
    parameter int CNT_W = 3
);
    logic                 en1;
    logic                 en2;
    logic [G1_W-1:0]      cond_group1;
    logic [G2_W-1:0]      cond_group2;
    logic                 wr_en;
    logic [G1_W+G2_W-1:0] wr_data;
    logic                 push;
    logic                 pop;
    logic                 err_clr;
    logic [G1_W-1:0]      final_group1;
    logic [G2_W-1:0]      final_group2;
    logic [CNT_W-1:0]     count;
    logic                 full;
    logic                 empty;
    logic                 ovf;
    logic                 unf;

    modport master (
        output en1, en2, cond_group1, cond_group2, wr_en, wr_data, push, pop, err_clr,
        input  final_group1, final_group2, count, full, empty, ovf, unf
    );
    modport slave (
        input  en1, en2, cond_group1, cond_group2, wr_en, wr_data, push, pop, err_clr,
        output final_group1, final_group2, count, full, empty, ovf, unf
    );
endinterface

// File: rtl/psr_flag_stack.sv
// Processor status flags (C,F / L,Z,N) with per-group update, software write,
// and a DEPTH-entry shadow stack for interrupt/call save and restore.
module psr_flag_stack #(
    parameter int G1_W  = 2,
    parameter int G2_W  = 3,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    psr_flag_stack_if.slave    bus
);
    localparam int W     = G1_W + G2_W;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     stack [DEPTH];
    logic [W-1:0]     cur_flags, nxt_flags, top_flags;
    logic [CNT_W-1:0] count_q;
    logic [IDX_W-1:0] top_idx, wr_idx;
    logic             ovf_q, unf_q;
    logic             has_data, at_full;
    logic             xchg, pop_only, push_only, push_store;
    logic             ovf_evt, unf_evt;

    assign cur_flags = {bus.final_group1, bus.final_group2};
    assign has_data  = (count_q != '0);
    assign at_full   = (count_q == CNT_W'(DEPTH));
    assign top_idx   = IDX_W'(count_q - 1'b1);
    assign wr_idx    = IDX_W'(count_q);
    assign top_flags = stack[top_idx];

    // A push+pop on an empty stack degenerates to a plain push.
    assign xchg       = bus.push && bus.pop && has_data;
    assign pop_only   = bus.pop && !bus.push && has_data;
    assign push_only  = bus.push && !(bus.pop && has_data);
    assign push_store = push_only && !at_full;
    assign ovf_evt    = push_only && at_full;
    assign unf_evt    = bus.pop && !bus.push && !has_data;

    always_comb begin
        nxt_flags = cur_flags;
        if (bus.pop && has_data) begin
            nxt_flags = top_flags;
        end else if (bus.wr_en) begin
            nxt_flags = bus.wr_data;
        end else begin
            if (bus.en1) nxt_flags[W-1 -: G1_W] = bus.cond_group1;
            if (bus.en2) nxt_flags[G2_W-1:0]    = bus.cond_group2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.final_group1 <= '0;
            bus.final_group2 <= '0;
            count_q          <= '0;
            ovf_q            <= 1'b0;
            unf_q            <= 1'b0;
        end else begin
            {bus.final_group1, bus.final_group2} <= nxt_flags;
            if (push_store)    count_q <= count_q + 1'b1;
            else if (pop_only) count_q <= count_q - 1'b1;
            // A fresh error outranks a simultaneous clear.
            if (ovf_evt)          ovf_q <= 1'b1;
            else if (bus.err_clr) ovf_q <= 1'b0;
            if (unf_evt)          unf_q <= 1'b1;
            else if (bus.err_clr) unf_q <= 1'b0;
        end
    end

    // Stack storage carries no reset; count alone defines what is valid.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (xchg)            stack[top_idx] <= cur_flags;
            else if (push_store) stack[wr_idx]  <= cur_flags;
        end
    end

    assign bus.count = count_q;
    assign bus.full  = at_full;
    assign bus.empty = !has_data;
    assign bus.ovf   = ovf_q;
    assign bus.unf   = unf_q;
endmodule

// File: tb/tb_psr_flag_stack.sv
// Scoreboard bench for psr_flag_stack: a queue-based reference model predicts
// every cycle's outputs, which are compared one cycle after the stimulus.
module tb_psr_flag_stack;
    localparam int G1_W  = 2;
    localparam int G2_W  = 3;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int W     = G1_W + G2_W;

    typedef struct {
        logic [G1_W-1:0] g1;
        logic [G2_W-1:0] g2;
        int              cnt;
        bit              full, empty, ovf, unf;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    exp_t         sbq[$];
    logic [W-1:0] m_stk[$];
    logic [W-1:0] m_flags = '0;
    bit           m_ovf = 0, m_unf = 0;

    psr_flag_stack_if #(.G1_W(G1_W), .G2_W(G2_W), .CNT_W(CNT_W)) bus();

    psr_flag_stack #(.G1_W(G1_W), .G2_W(G2_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic idle();
        reset           = 1'b0;
        bus.en1         = 1'b0;
        bus.en2         = 1'b0;
        bus.cond_group1 = '0;
        bus.cond_group2 = '0;
        bus.wr_en       = 1'b0;
        bus.wr_data     = '0;
        bus.push        = 1'b0;
        bus.pop         = 1'b0;
        bus.err_clr     = 1'b0;
    endtask

    // Reference model: stack held as a queue, top at the back.
    task automatic model_step();
        logic [W-1:0] cur, nf;
        bit e_ovf, e_unf;
        int cnt;
        exp_t e;
        cur = m_flags; nf = cur; e_ovf = 0; e_unf = 0;
        cnt = m_stk.size();
        if (reset) begin
            m_stk.delete();
            m_flags = '0; m_ovf = 0; m_unf = 0;
        end else begin
            if (bus.pop && cnt > 0) begin
                nf = m_stk[cnt-1];
                if (bus.push) m_stk[cnt-1] = cur;
                else void'(m_stk.pop_back());
            end else begin
                if (bus.wr_en) nf = bus.wr_data;
                else begin
                    if (bus.en1) nf[W-1:G2_W] = bus.cond_group1;
                    if (bus.en2) nf[G2_W-1:0] = bus.cond_group2;
                end
                if (bus.push) begin
                    if (cnt < DEPTH) m_stk.push_back(cur);
                    else e_ovf = 1;
                end else if (bus.pop) e_unf = 1;
            end
            m_flags = nf;
            m_ovf = e_ovf ? 1'b1 : (bus.err_clr ? 1'b0 : m_ovf);
            m_unf = e_unf ? 1'b1 : (bus.err_clr ? 1'b0 : m_unf);
        end
        e.g1 = m_flags[W-1:G2_W];
        e.g2 = m_flags[G2_W-1:0];
        e.cnt = m_stk.size();
        e.full = (e.cnt == DEPTH);
        e.empty = (e.cnt == 0);
        e.ovf = m_ovf;
        e.unf = m_unf;
        sbq.push_back(e);
    endtask

    task automatic cyc(input string tag);
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk({tag, ".sbq"}, 32'(sbq.size()), 32'd1);
        end else begin
            e = sbq.pop_front();
            chk({tag, ".g1"},    32'(bus.final_group1), 32'(e.g1));
            chk({tag, ".g2"},    32'(bus.final_group2), 32'(e.g2));
            chk({tag, ".count"}, 32'(bus.count),        32'(e.cnt));
            chk({tag, ".full"},  32'(bus.full),         32'(e.full));
            chk({tag, ".empty"}, 32'(bus.empty),        32'(e.empty));
            chk({tag, ".ovf"},   32'(bus.ovf),          32'(e.ovf));
            chk({tag, ".unf"},   32'(bus.unf),          32'(e.unf));
        end
    endtask

    task automatic wr(input logic [W-1:0] d);
        idle(); bus.wr_en = 1'b1; bus.wr_data = d; cyc("wr");
    endtask

    task automatic do_reset();
        idle(); reset = 1'b1; cyc("reset");
    endtask

    initial begin
        idle();
        do_reset();
        chk("reset.g1", 32'(bus.final_group1), 32'd0);
        chk("reset.count", 32'(bus.count), 32'd0);

        // Group 1 loads, group 2 holds.
        idle(); bus.en1 = 1'b1; bus.cond_group1 = 2'b11; bus.cond_group2 = 3'b101; cyc("en1");
        chk("en1.direct", 32'({bus.final_group1, bus.final_group2}), 32'(5'b11000));

        // Save, overwrite, restore.
        wr(5'b11010);
        idle(); bus.push = 1'b1; cyc("push1");
        idle(); bus.en1 = 1'b1; bus.en2 = 1'b1; bus.cond_group1 = 2'b00; bus.cond_group2 = 3'b001; cyc("en12");
        idle(); bus.pop = 1'b1; cyc("pop1");
        chk("pop1.direct", 32'({bus.final_group1, bus.final_group2, bus.empty}), 32'(6'b110101));

        // Push stores pre-update flags while the update still applies.
        wr(5'b10000);
        idle(); bus.push = 1'b1; bus.en1 = 1'b1; bus.cond_group1 = 2'b01; cyc("push_upd");
        chk("push_upd.direct", 32'({bus.final_group1, bus.final_group2}), 32'(5'b01000));
        idle(); bus.pop = 1'b1; cyc("pop_upd");
        chk("pop_upd.direct", 32'({bus.final_group1, bus.final_group2}), 32'(5'b10000));

        // Overflow and sticky clear behaviour.
        for (int i = 0; i < 5; i++) begin
            idle(); bus.push = 1'b1; bus.en2 = 1'b1; bus.cond_group2 = 3'(i); cyc("fill");
        end
        chk("fill.ovf", 32'({bus.count, bus.full, bus.ovf}), 32'({3'd4, 1'b1, 1'b1}));
        idle(); bus.err_clr = 1'b1; cyc("clr");
        idle(); bus.err_clr = 1'b1; bus.push = 1'b1; cyc("clr_push");
        chk("clr_push.ovf", 32'(bus.ovf), 32'd1);

        // Underflow with write; pop beats write when data exists.
        do_reset();
        idle(); bus.pop = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 5'b10110; cyc("unf_wr");
        chk("unf_wr.direct", 32'({bus.final_group1, bus.final_group2, bus.unf}), 32'(6'b101101));
        idle(); bus.push = 1'b1; cyc("push_a");
        wr(5'b00111);
        idle(); bus.pop = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 5'b01010; cyc("pop_wr");
        chk("pop_wr.direct", 32'({bus.final_group1, bus.final_group2}), 32'(5'b10110));

        // Exchange at count 2, then push+pop on empty.
        do_reset();
        wr(5'b00000); idle(); bus.push = 1'b1; cyc("px1");
        wr(5'b01100); idle(); bus.push = 1'b1; cyc("px2");
        wr(5'b10011);
        idle(); bus.push = 1'b1; bus.pop = 1'b1; cyc("xchg");
        chk("xchg.direct", 32'({bus.final_group1, bus.final_group2, bus.count}), 32'({5'b01100, 3'd2}));
        idle(); bus.pop = 1'b1; cyc("xchg_top");
        chk("xchg_top.direct", 32'({bus.final_group1, bus.final_group2}), 32'(5'b10011));
        do_reset();
        idle(); bus.push = 1'b1; bus.pop = 1'b1; cyc("xchg_empty");
        chk("xchg_empty.direct", 32'({bus.count, bus.unf}), 32'({3'd1, 1'b0}));

        // Random traffic, occasional reset mid-sequence.
        for (int i = 0; i < 400; i++) begin
            idle();
            reset           = ($urandom_range(0, 59) == 0);
            bus.en1         = 1'($urandom);
            bus.en2         = 1'($urandom);
            bus.cond_group1 = G1_W'($urandom);
            bus.cond_group2 = G2_W'($urandom);
            bus.wr_en       = ($urandom_range(0, 3) == 0);
            bus.wr_data     = W'($urandom);
            bus.push        = ($urandom_range(0, 2) == 0);
            bus.pop         = ($urandom_range(0, 2) == 0);
            bus.err_clr     = ($urandom_range(0, 7) == 0);
            cyc("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
